// File: rtl/pc_gen_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : pc_gen_pkg                                                  |
// | Purpose : Shared constants and state encoding for the fetch-stage    |
// |           program-counter generator.                                  |
// | Contents: reset/chip-enable levels, default XLEN and reset vector,    |
// |           FSM state type.                                             |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package pc_gen_pkg;

   localparam logic RST_ENABLE   = 1'b1;
   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   localparam int XLEN_DEFAULT = 32;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : pc_gen_if                                                   |
// | Purpose : Bundle of control inputs and fetch-side outputs of pc_gen.  |
// | Ports   : master - drives stall/redirect/ready, observes PC outputs.  |
// |           slave  - the PC generator side.                             |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            stall_i;
   logic            branch_valid_i;
   logic [XLEN-1:0] branch_target_i;
   logic            trap_valid_i;
   logic [XLEN-1:0] trap_vector_i;
   logic            fetch_ready_i;
   logic [XLEN-1:0] pc_o;
   logic            pc_valid_o;
   logic            ce_o;
   logic            misaligned_o;
   logic [XLEN-1:0] misaligned_pc_o;

   modport master (
      output stall_i, branch_valid_i, branch_target_i,
             trap_valid_i, trap_vector_i, fetch_ready_i,
      input  pc_o, pc_valid_o, ce_o, misaligned_o, misaligned_pc_o
   );

   modport slave (
      input  stall_i, branch_valid_i, branch_target_i,
             trap_valid_i, trap_vector_i, fetch_ready_i,
      output pc_o, pc_valid_o, ce_o, misaligned_o, misaligned_pc_o
   );
endinterface : pc_gen_if
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : pc_next_sel                                                 |
// | Purpose : Combinational next-PC selection: trap > branch > increment  |
// |           > hold, with trap alignment clear and misalign detect.      |
// | Ports   : pc_i current PC; trap/branch requests and targets;          |
// |           accept_i fetch handshake; next_pc_o selected PC;            |
// |           misaligned_o branch target rejected as misaligned.          |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module pc_next_sel #(
   parameter int XLEN       = 32,
   parameter int INST_BYTES = 4
) (
   input  wire logic [XLEN-1:0] pc_i,
   input  wire logic            trap_valid_i,
   input  wire logic [XLEN-1:0] trap_vector_i,
   input  wire logic            branch_valid_i,
   input  wire logic [XLEN-1:0] branch_target_i,
   input  wire logic            accept_i,
   output logic      [XLEN-1:0] next_pc_o,
   output logic                 misaligned_o
);

   // Mask of the address bits below instruction granularity; zero when
   // INST_BYTES is 1, so every target is then aligned.
   localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);
   localparam logic [XLEN-1:0] STEP     = XLEN'(INST_BYTES);

   always_comb begin
      next_pc_o    = pc_i;
      misaligned_o = 1'b0;
      if (trap_valid_i) begin
         // Trap wins outright; the branch is not even checked for alignment.
         next_pc_o = trap_vector_i & ~LOW_MASK;
      end else if (branch_valid_i) begin
         if ((branch_target_i & LOW_MASK) == '0) begin
            next_pc_o = branch_target_i;
         end else begin
            misaligned_o = 1'b1;
         end
      end else if (accept_i) begin
         // Natural modulo-2^XLEN wrap, no flag.
         next_pc_o = pc_i + STEP;
      end
   end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : pc_gen                                                      |
// | Purpose : Fetch-stage program-counter generator. Issues addresses     |
// |           from RESET_VECTOR, advances on accepted fetches, takes      |
// |           branch and trap redirects, parks misaligned branches in a   |
// |           FAULT state until a trap redirect arrives.                  |
// | Ports   : clk, rst (synchronous, active-high); bus (pc_gen_if.slave)  |
// |           carrying stall/redirect/ready inputs and PC outputs.        |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEFAULT,
   parameter int              INST_BYTES   = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
   input wire logic clk,
   input wire logic rst,
   pc_gen_if.slave  bus
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] mis_pc_q, mis_pc_d;

   logic            in_run;
   logic            pc_valid;
   logic            accept;
   logic [XLEN-1:0] sel_pc;
   logic            sel_misaligned;

   assign in_run   = (state_q == ST_RUN);
   // The only combinational output: the request drops in the stall cycle.
   assign pc_valid = in_run && !bus.stall_i;
   assign accept   = pc_valid && bus.fetch_ready_i;

   // Branches are only honoured in RUN; gating here lets the FAULT state
   // reuse the same selector for its trap-only exit and hold.
   pc_next_sel #(
      .XLEN       (XLEN),
      .INST_BYTES (INST_BYTES)
   ) u_pc_next_sel (
      .pc_i            (pc_q),
      .trap_valid_i    (bus.trap_valid_i),
      .trap_vector_i   (bus.trap_vector_i),
      .branch_valid_i  (bus.branch_valid_i && in_run),
      .branch_target_i (bus.branch_target_i),
      .accept_i        (accept),
      .next_pc_o       (sel_pc),
      .misaligned_o    (sel_misaligned)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      mis_pc_d = mis_pc_q;
      case (state_q)
         ST_RESET: begin
            state_d = ST_RUN;
            pc_d    = RESET_VECTOR;
         end
         ST_RUN: begin
            pc_d = sel_pc;
            if (sel_misaligned) begin
               state_d  = ST_FAULT;
               mis_pc_d = bus.branch_target_i;
            end
         end
         ST_FAULT: begin
            pc_d = sel_pc;
            if (bus.trap_valid_i) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RESET;
            pc_d    = RESET_VECTOR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q  <= ST_RESET;
         pc_q     <= RESET_VECTOR;
         mis_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         mis_pc_q <= mis_pc_d;
      end
   end

   assign bus.pc_o            = pc_q;
   assign bus.pc_valid_o      = pc_valid;
   assign bus.ce_o            = (state_q != ST_RESET) ? CHIP_ENABLE : CHIP_DISABLE;
   assign bus.misaligned_o    = (state_q == ST_FAULT);
   assign bus.misaligned_pc_o = mis_pc_q;

endmodule : pc_gen
`default_nettype wire
